// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and constants for the SRAM burst controller.
package sram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // SRAM read data appears one cycle after the issue (oe cycle).
    localparam int RD_LATENCY = 1;
    // Output FIFO depth; also the total read credit (buffered + in flight).
    localparam int BUF_DEPTH  = 2;

endpackage

// File: rtl/single_port_ram_intf.sv
// Single-port SRAM bus: cs/oe strobes, active-low write request, 1-cycle read.
interface single_port_ram_intf #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          cs;
    logic          oe;
    logic          W_req;
    logic [AW-1:0] addr;
    logic [DW-1:0] W_data;
    logic [DW-1:0] R_data;

    modport controller (output cs, oe, W_req, addr, W_data, input R_data);
    modport target     (input cs, oe, W_req, addr, W_data, output R_data);
endinterface

// File: rtl/sram_rd_fifo.sv
// Two-entry read-data FIFO; push and pop may happen in the same cycle.
module sram_rd_fifo #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    output logic [1:0]           count_o
);
    logic [DataWidth-1:0] data_q [2];
    logic                 wr_q, rd_q;
    logic [1:0]           cnt_q;
    logic                 push_ok, pop_ok;

    assign pop_ok  = pop_i & (cnt_q != 2'd0);
    assign push_ok = push_i & ((cnt_q != 2'd2) | pop_ok);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push_ok) begin
                data_q[wr_q] <= data_i;
                wr_q         <= ~wr_q;
            end
            if (pop_ok) rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign data_o  = data_q[rd_q];
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller driving a single-port parameter SRAM.
// Write beats go straight to the SRAM; reads are credit-limited into a
// 2-entry FIFO so backpressure never loses a word.
// Optional macro SRAM_BURST_BOUND_CHK_EN: drop bursts that run past the end
// of the SRAM and pulse err instead of wrapping.
module sram_burst_ctrl import sram_burst_pkg::*; #(
    parameter int Words     = 4,
    parameter int AddrWidth = $clog2(Words),
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_base,
    input  logic [AddrWidth-1:0] cmd_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DataWidth-1:0] wdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [DataWidth-1:0] rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    single_port_ram_intf.controller mem
);
    state_e               state_q, state_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d, beat_q, beat_d, len_q, len_d;
    logic                 inflight_q, wr_done_q, wr_done_d;
    logic                 cmd_acc, wr_beat, rd_issue, pop, drain_fin, bound_bad;
    logic [1:0]           fifo_cnt;
    logic [2:0]           used, room;

    assign cmd_ready   = (state_q == IDLE) & rstn;
    assign cmd_acc     = cmd_valid & cmd_ready;
    assign busy        = (state_q != IDLE);
    assign wdata_ready = (state_q == WRITE);
    assign wr_beat     = (state_q == WRITE) & wdata_valid;
    assign pop         = rdata_valid & rdata_ready;

    // Credit: a pop this cycle frees a slot, keeping 1 word/cycle streaming.
    assign used     = {1'b0, fifo_cnt} + {2'b0, inflight_q};
    assign room     = 3'(BUF_DEPTH) + {2'b0, pop};
    assign rd_issue = (state_q == READ) && (used < room);

    assign drain_fin = (state_q == DRAIN) && !inflight_q && (fifo_cnt == 2'd1) && pop;
    assign done      = wr_done_q | drain_fin;

`ifdef SRAM_BURST_BOUND_CHK_EN
    logic err_q;
    assign bound_bad = ({1'b0, cmd_base} + {1'b0, cmd_len} + (AddrWidth+1)'(1))
                       > (AddrWidth+1)'(Words);
    // Rejected command reports one cycle after acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= cmd_acc & bound_bad;
    end
    assign err = err_q;
`else
    assign bound_bad = 1'b0;
    assign err       = 1'b0;
`endif

    // SRAM strobes: write beats and read issues are combinational; oe marks the
    // data-return cycle of the previous issue.
    assign mem.cs     = wr_beat | rd_issue;
    assign mem.W_req  = ~wr_beat;
    assign mem.oe     = inflight_q;
    assign mem.W_data = wr_beat ? wdata : '0;

    // Zero-extend the word pointer onto the bus address; idle bus sits at 0.
    always_comb begin
        mem.addr = '0;
        if (wr_beat | rd_issue) mem.addr[AddrWidth-1:0] = ptr_q;
    end

    // Burst FSM next-state and pointer/beat bookkeeping.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        len_d     = len_q;
        wr_done_d = 1'b0;
        case (state_q)
            IDLE: if (cmd_acc && !bound_bad) begin
                ptr_d   = cmd_base;
                beat_d  = '0;
                len_d   = cmd_len;
                state_d = cmd_write ? WRITE : READ;
            end
            WRITE: if (wr_beat) begin
                ptr_d  = ptr_q + 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == len_q) begin
                    state_d   = IDLE;
                    wr_done_d = 1'b1;
                end
            end
            READ: if (rd_issue) begin
                ptr_d  = ptr_q + 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == len_q) state_d = DRAIN;
            end
            DRAIN: if (drain_fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            inflight_q <= rd_issue;
            wr_done_q  <= wr_done_d;
        end
    end

    sram_rd_fifo #(.DataWidth(DataWidth)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (inflight_q),
        .data_i  (mem.R_data),
        .pop_i   (pop),
        .data_o  (rdata),
        .valid_o (rdata_valid),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed scoreboard bench for sram_burst_ctrl with a behavioural SRAM.
module tb_sram_burst_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_base, cmd_len;
    logic        wdata_valid, wdata_ready, rdata_valid, rdata_ready;
    logic [31:0] wdata, rdata;
    logic        busy, done, err;

    single_port_ram_intf #(.AW(8), .DW(32)) mem_if ();

    sram_burst_ctrl #(.Words(4), .AddrWidth(2), .DataWidth(32)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .busy(busy), .done(done), .err(err),
        .mem(mem_if)
    );

    // Behavioural SRAM: 1-cycle read, data driven only while oe is high.
    logic [31:0] sram [4];
    logic [31:0] rd_lat;
    always @(posedge clk) begin
        if (mem_if.cs && !mem_if.W_req) sram[mem_if.addr[1:0]] <= mem_if.W_data;
        if (mem_if.cs &&  mem_if.W_req) rd_lat <= sram[mem_if.addr[1:0]];
    end
    assign mem_if.R_data = mem_if.oe ? rd_lat : 32'h0;

    typedef struct packed { logic we; logic [1:0] addr; logic [31:0] data; } acc_t;
    typedef struct packed { logic [31:0] data; logic last; logic [31:0] cyc; } rd_t;

    acc_t exp_acc[$], obs_acc[$];
    rd_t  exp_rd[$],  obs_rd[$];
    logic [31:0] model_mem [4];

    int total = 0, bad = 0;
    int unsigned cyc = 0, iss = 0, pops = 0, cred_viol = 0, idle_cs = 0;
    int unsigned done_cnt = 0, err_cnt = 0;

    // Monitor: log SRAM accesses and FIFO pops; track read credit usage.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            iss  <= 0;
            pops <= 0;
        end else begin
            if (mem_if.cs) begin
                obs_acc.push_back(acc_t'{we: !mem_if.W_req, addr: mem_if.addr[1:0],
                                         data: mem_if.W_data});
                if (!busy) idle_cs <= idle_cs + 1;
                if (mem_if.W_req) begin
                    if (iss + 1 > pops + ((rdata_valid && rdata_ready) ? 1 : 0) + 2)
                        cred_viol <= cred_viol + 1;
                    iss <= iss + 1;
                end
            end
            if (rdata_valid && rdata_ready) begin
                obs_rd.push_back(rd_t'{data: rdata, last: done, cyc: cyc});
                pops <= pops + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (err)  err_cnt  <= err_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, o, e);
        end
    endtask

    task automatic chk_rst_outputs(input string p);
        chk({p, "_cs"},     mem_if.cs, 0);
        chk({p, "_oe"},     mem_if.oe, 0);
        chk({p, "_wreq"},   mem_if.W_req, 1);
        chk({p, "_addr"},   mem_if.addr, 0);
        chk({p, "_wdata"},  mem_if.W_data, 0);
        chk({p, "_cready"}, cmd_ready, 0);
        chk({p, "_wready"}, wdata_ready, 0);
        chk({p, "_rvalid"}, rdata_valid, 0);
        chk({p, "_busy"},   busy, 0);
        chk({p, "_done"},   done, 0);
        chk({p, "_err"},    err, 0);
    endtask

    task automatic send_cmd(input logic w, input logic [1:0] base, input logic [1:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_base = base; cmd_len = len;
        while (!cmd_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("cmd_accept_timeout", n < 40, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [1:0] base, input logic [1:0] len, input logic [31:0] seed);
        logic [1:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 2'(i);
            model_mem[a] = seed + 32'(i);
            exp_acc.push_back(acc_t'{we: 1'b1, addr: a, data: seed + 32'(i)});
        end
    endtask

    task automatic push_rd(input logic [1:0] base, input logic [1:0] len);
        logic [1:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 2'(i);
            exp_acc.push_back(acc_t'{we: 1'b0, addr: a, data: 32'h0});
            exp_rd.push_back(rd_t'{data: model_mem[a], last: (i == int'(len)), cyc: 32'h0});
        end
    endtask

    task automatic cmp_acc();
        acc_t e, o;
        chk("acc_count", obs_acc.size(), exp_acc.size());
        while (exp_acc.size() > 0 && obs_acc.size() > 0) begin
            e = exp_acc.pop_front();
            o = obs_acc.pop_front();
            chk("acc_we", o.we, e.we);
            chk("acc_addr", o.addr, e.addr);
            if (e.we) chk("acc_wdata", o.data, e.data);
        end
        exp_acc.delete();
        obs_acc.delete();
    endtask

    task automatic cmp_rd(input bit consec);
        rd_t e, o;
        logic [31:0] prev = 0;
        bit first = 1;
        chk("rd_count", obs_rd.size(), exp_rd.size());
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = obs_rd.pop_front();
            chk("rd_data", o.data, e.data);
            chk("rd_done_on_last", o.last, e.last);
            if (consec && !first) chk("rd_consecutive", o.cyc, prev + 1);
            prev  = o.cyc;
            first = 0;
        end
        exp_rd.delete();
        obs_rd.delete();
    endtask

    task automatic wr_burst(input logic [1:0] base, input logic [1:0] len, input logic [31:0] seed);
        push_wr(base, len, seed);
        send_cmd(1'b1, base, len);
        for (int i = 0; i <= int'(len); i++) begin
            wdata_valid = 1'b1;
            wdata = seed + 32'(i);
            chk("wdata_ready", wdata_ready, 1);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
        chk("wr_done_pulse", done, 1);
        chk("wr_busy_after", busy, 0);
        @(posedge clk); #1;
        chk("wr_done_single", done, 0);
        cmp_acc();
    endtask

    task automatic rd_burst(input logic [1:0] base, input logic [1:0] len,
                            input logic [3:0] pat, input bit consec);
        int k = 0;
        push_rd(base, len);
        rdata_ready = 1'b0;
        send_cmd(1'b0, base, len);
        while (obs_rd.size() < int'(len) + 1 && k < 100) begin
            rdata_ready = pat[k % 4];
            @(posedge clk); #1;
            k++;
        end
        rdata_ready = 1'b0;
        chk("rd_timeout", k < 100, 1);
        chk("rd_busy_after", busy, 0);
        cmp_acc();
        cmp_rd(consec);
    endtask

    initial begin
        int exp_done = 0;
        int d0;
        rstn = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_base = 0; cmd_len = 0;
        wdata_valid = 0; wdata = 0; rdata_ready = 0;
        #1 rstn = 1'b0;
        #2 chk_rst_outputs("reset");
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // 1: write A0..A3 then stream them back at full rate
        wr_burst(2'd0, 2'd3, 32'hA000_0000); exp_done++;
        rd_burst(2'd0, 2'd3, 4'b1111, 1'b1); exp_done++;

        // 2: wrapping read 3 -> 0
        rd_burst(2'd3, 2'd1, 4'b1111, 1'b0); exp_done++;

        // 3: backpressure pattern 1,0,0,1
        rd_burst(2'd0, 2'd3, 4'b1001, 1'b0); exp_done++;
        chk("credit_respected", cred_viol, 0);

        // 4: second command held during a busy write
        push_wr(2'd1, 2'd1, 32'hC0DE_0000);
        send_cmd(1'b1, 2'd1, 2'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 2'd2; cmd_len = 2'd0;
        push_rd(2'd2, 2'd0);
        for (int i = 0; i < 2; i++) begin
            chk("ready_low_busy", cmd_ready, 0);
            wdata_valid = 1'b1; wdata = 32'hC0DE_0000 + 32'(i);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
        chk("ready_back_idle", cmd_ready, 1);
        chk("t4_wr_done", done, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t4_rd_accepted", busy, 1);
        rdata_ready = 1'b1;
        for (int k = 0; k < 20 && obs_rd.size() < 1; k++) begin @(posedge clk); #1; end
        rdata_ready = 1'b0;
        exp_done += 2;
        cmp_acc();
        cmp_rd(1'b0);

        // 5: reset mid-read after two issues
        d0 = int'(done_cnt);
        exp_acc.push_back(acc_t'{we: 1'b0, addr: 2'd0, data: 32'h0});
        exp_acc.push_back(acc_t'{we: 1'b0, addr: 2'd1, data: 32'h0});
        rdata_ready = 1'b0;
        send_cmd(1'b0, 2'd0, 2'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1 chk_rst_outputs("midrst");
        cmp_acc();
        chk("midrst_no_pop", obs_rd.size(), 0);
        @(posedge clk); #1;
        chk("midrst_no_done", done_cnt, d0);
        rstn = 1'b1;
        @(posedge clk); #1;
        rd_burst(2'd0, 2'd3, 4'b1111, 1'b1); exp_done++;

`ifdef SRAM_BURST_BOUND_CHK_EN
        // 6: out-of-range command is dropped
        send_cmd(1'b0, 2'd3, 2'd1);
        chk("oob_err", err, 1);
        chk("oob_busy", busy, 0);
        @(posedge clk); #1;
        chk("oob_err_single", err, 0);
        chk("oob_no_access", obs_acc.size(), 0);
        chk("oob_err_cnt", err_cnt, 1);
`else
        chk("err_never", err_cnt, 0);
`endif
        chk("done_total", done_cnt, exp_done);
        chk("no_idle_cs", idle_cs, 0);
        chk("credit_final", cred_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
